// File: rtl/s2p_pkg.sv
// Shared definitions for the s2p frame sequencer.
//   NIB_W        - nibble width delivered by the s2p converter
//   SYNC_DEFAULT - default sync nibble marking the start of a frame
//   state_e      - sequencer FSM states
package s2p_pkg;

  localparam int unsigned NIB_W = 4;
  localparam logic [NIB_W-1:0] SYNC_DEFAULT = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    RECV,
    DRAIN
  } state_e;

endpackage

// File: rtl/s2p_byte_pack.sv
// Packs nibble pairs into bytes and presents them through a one-entry
// valid/ready output register. A byte completing while the register is
// full and not being drained is dropped and flagged as overflow.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        clears the sticky overflow flag
//   i_restart      resynchronises nibble pairing (next nibble is high half)
//   i_nib_valid    nibble strobe (already qualified by the caller)
//   i_nib          nibble data
//   i_ready        sink accepts the held byte
//   o_data         held byte, first nibble in [7:4]
//   o_valid        held byte available
//   o_overflow     sticky dropped-byte flag
//   o_byte_done    combinational: this cycle's nibble completes a byte
module s2p_byte_pack
  import s2p_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_restart,
  input  logic             i_nib_valid,
  input  logic [NIB_W-1:0] i_nib,
  input  logic             i_ready,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_byte_done
);

  logic             r_odd;
  logic [NIB_W-1:0] r_hold;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ovf;

  assign o_byte_done = i_nib_valid && r_odd;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_overflow  = r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_odd   <= 1'b0;
      r_hold  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_restart) begin
        r_odd <= 1'b0;
      end else if (i_nib_valid) begin
        r_odd <= ~r_odd;
        if (!r_odd) begin
          r_hold <= i_nib;
        end
      end

      // A full register being drained this cycle can take the new byte.
      if (o_byte_done) begin
        if (!r_valid || i_ready) begin
          r_data  <= {r_hold, i_nib};
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_clear) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer for the 4-bit serial-to-parallel converter: enables s2p
// on a start request, hunts for the sync nibble, packs the following nibble
// pairs into bytes for a valid/ready sink, and stops after frame_len bytes.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         frame request (IDLE only); frame_len latched with it
//   s2p_en        enable to the s2p converter
//   s2p_data      nibble from s2p
//   s2p_valid     nibble strobe from s2p
//   word_data     assembled byte; word_valid/word_ready handshake
//   busy          sequencer not idle
//   done          one-cycle frame completion pulse
//   sync_err      sticky hunt timeout
//   overflow      sticky dropped byte
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter logic [NIB_W-1:0] SYNC     = SYNC_DEFAULT,
  parameter int unsigned      LEN_W    = 5,
  parameter int unsigned      HUNT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             s2p_en,
  input  logic [NIB_W-1:0] s2p_data,
  input  logic             s2p_valid,
  output logic [7:0]       word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             done,
  output logic             sync_err,
  output logic             overflow
);

  localparam int unsigned HW = $clog2(HUNT_MAX + 1);
  localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_MAX - 1);

  state_e           r_state;
  state_e           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [HW-1:0]    r_hunt_cnt;
  logic             r_done;
  logic             r_sync_err;

  logic             w_accept;
  logic             w_nib_valid;
  logic             w_byte_done;
  logic             w_word_valid;
  logic             w_sync_hit;
  logic             w_timeout;
  logic             w_done_nxt;

  // Any start seen in IDLE clears the flags, including a zero-length one.
  assign w_accept    = (r_state == IDLE) && start;
  assign w_nib_valid = s2p_valid && (r_state == RECV);

  assign s2p_en     = (r_state == HUNT) || (r_state == RECV);
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign sync_err   = r_sync_err;
  assign word_valid = w_word_valid;

  s2p_byte_pack u_pack (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (w_accept),
    .i_restart   (w_sync_hit),
    .i_nib_valid (w_nib_valid),
    .i_nib       (s2p_data),
    .i_ready     (word_ready),
    .o_data      (word_data),
    .o_valid     (w_word_valid),
    .o_overflow  (overflow),
    .o_byte_done (w_byte_done)
  );

  always_comb begin
    w_next     = r_state;
    w_sync_hit = 1'b0;
    w_timeout  = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) w_next = HUNT;
          else                 w_done_nxt = 1'b1;
        end
      end
      HUNT: begin
        if (s2p_valid) begin
          if (s2p_data == SYNC) begin
            w_sync_hit = 1'b1;
            w_next     = RECV;
          end else if (r_hunt_cnt == HUNT_LAST) begin
            w_timeout = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      RECV: begin
        if (w_byte_done && (r_byte_cnt == r_len - LEN_W'(1))) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_word_valid || word_ready) begin
          w_done_nxt = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_hunt_cnt <= '0;
      r_done     <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_sync_err <= 1'b0;
        r_hunt_cnt <= '0;
        if (frame_len != '0) begin
          r_len <= frame_len;
        end
      end
      if ((r_state == HUNT) && s2p_valid) begin
        if (w_sync_hit) begin
          r_byte_cnt <= '0;
        end else begin
          r_hunt_cnt <= r_hunt_cnt + HW'(1);
          if (w_timeout) begin
            r_sync_err <= 1'b1;
          end
        end
      end
      if ((r_state == RECV) && w_byte_done) begin
        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Sequencer for the 4-bit serial-to-parallel converter (s2p). It enables s2p on command, hunts for a sync nibble, packs the following nibble pairs into bytes, and hands each byte to a downstream sink over a valid/ready handshake. It disables s2p after a programmed number of bytes and reports sync timeout and overflow errors.

Parameters:
SYNC, 4'hA, sync nibble that marks the start of a frame
LEN_W, 5, width of frame_len in bytes
HUNT_MAX, 15, non-sync nibbles tolerated in HUNT before timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle frame request; sampled in IDLE only
frame_len  in  LEN_W  bytes to receive; latched on accepted start
s2p_en  out  1  enable to s2p converter
s2p_data  in  4  nibble from s2p (data_out)
s2p_valid  in  1  nibble strobe from s2p (data_out_valid)
word_data  out  8  assembled byte; first nibble in [7:4]
word_valid  out  1  byte available
word_ready  in  1  sink accepts byte
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame completion
sync_err  out  1  sticky hunt timeout; cleared by accepted start
overflow  out  1  sticky dropped byte; cleared by accepted start

Behaviour:
- Reset: rst sampled at the clk edge. All outputs are 0 after that edge, the FSM is in IDLE, and counters and the hold register are cleared. Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, HUNT, RECV, DRAIN.
- IDLE: s2p_en=0; s2p_valid is ignored.
  - start with frame_len!=0: latch the length, clear sync_err and overflow, go to HUNT. s2p_en=1 from the next cycle.
  - start with frame_len==0: clear the flags, pulse done on the next cycle, never assert s2p_en, stay in IDLE.
- HUNT: on each s2p_valid:
  - s2p_data==SYNC: go to RECV, reset the nibble and byte counters.
  - Otherwise increment hunt_cnt. When it reaches HUNT_MAX, set sync_err, drop s2p_en, return to IDLE; done is not pulsed.
- RECV: on each s2p_valid, alternate nibbles:
  - Even nibble: stored in hold[7:4].
  - Odd nibble: completes {hold[7:4], s2p_data}. The byte counter increments whether the byte is delivered or dropped.
  - Sync-pattern nibbles inside RECV are treated as data.
  - When the byte count reaches the latched length: s2p_en=0 next cycle, go to DRAIN.
- DRAIN: wait until word_valid==0 or word_valid&&word_ready. Then pulse done for 1 cycle and go to IDLE.
- Output register, single entry:
  - word_valid rises the cycle after the byte completes.
  - Held stable, data included, until word_valid&&word_ready.
  - Byte completes while word_valid=1 and word_ready=1 in the same cycle: the new byte loads, word_valid stays 1, no overflow.
  - Byte completes while word_valid=1 and word_ready=0: the new byte is dropped, overflow=1, the held byte is unchanged.
- start while busy is ignored.
- Latency: s2p_valid for the odd nibble to word_valid = 1 cycle.
- A nibble arrives at most every 4 clocks from s2p, so overflow only occurs when the sink stalls for 8 or more cycles.

Decomposition:
- Package s2p_pkg: FSM state enum (IDLE/HUNT/RECV/DRAIN), NIB_W=4, default SYNC=4'hA.
- Sub-module s2p_byte_pack: nibble-pair packing, hold register, and the one-entry valid/ready output register with overflow detect.
- s2p_frame_ctrl keeps the FSM, the counters and the s2p_en/done/sync_err logic.

Test Plan:
1. After reset, start with frame_len=2, word_ready=1, nibbles A,1,2,3,4 -> s2p_en=1 from the cycle after start; bytes 0x12 then 0x34; one done pulse; s2p_en=0; busy=0.
2. frame_len=1, nibbles 5,F,A,C,D -> only 0xCD delivered; no byte formed from 5 or F; done pulses once.
3. frame_len=3, 15 nibbles of 0x3 -> sync_err=1; s2p_en=0; busy=0; word_valid never 1; done never pulses.
4. frame_len=2, word_ready=0, nibbles A,1,2,3,4 -> 0x12 held; 0x34 dropped; overflow=1. Raise word_ready -> 0x12 accepted, then done pulses; overflow stays 1 until the next start.
5. rst asserted mid-RECV -> all outputs 0 after that edge; no done pulse. A following frame with len=1, nibbles A,5,6 yields 0x56.
6. start asserted while busy is ignored (the latched length is unchanged). start with frame_len=0 in IDLE -> done pulses on the next cycle; s2p_en stays 0.
